rr_gate_arbiter: RTL and testbench
==================================

Name: rr_gate_arbiter

Overview:
- Round-robin arbiter that shares one gate-level evaluation resource (a timed primitive-cell test slot) among up to 8 requesters.
- Issues a one-hot registered grant and holds it until the owner signals DONE, drops its request, or a hold timeout expires.
- Sits between the cell-test sequencers and the shared stimulus/compare path of the simulation library bench.

Parameters:
- N_REQ, 4, number of requesters; legal 2..8.
- MAX_HOLD, 16, maximum grant length in cycles; 0 disables the timeout; legal 0..255.

Ports:
- CK  input  1  rising-edge clock.
- CD  input  1  synchronous active-high reset (clear).
- REQ  input  N_REQ  request vector; bit i high = requester i wants the resource.
- DONE  input  1  owner releases the resource; sampled only while BUSY=1.
- GNT  output  N_REQ  registered one-hot grant; all-zero when idle.
- GID  output  3  binary index of the current/last grantee.
- BUSY  output  1  high while any GNT bit is high.
- TMO  output  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset: CD=1 at a CK edge forces GNT=0, GID=0, BUSY=0, TMO=0, priority pointer PTR=0, hold counter CNT=0, state IDLE. CD has priority over all other inputs and aborts any active grant in the same edge.
- States: IDLE, OWN, GAP.
- IDLE:
  - If REQ!=0, the next edge selects the first set bit scanning PTR, PTR+1, ... wrapping modulo N_REQ.
  - That edge sets GNT[k]=1, GID=k, BUSY=1, CNT=0 and enters OWN.
  - Grant latency is 1 cycle from the REQ sample.
- OWN (owner k), evaluated each edge in priority order:
  1. DONE=1 -> release.
  2. REQ[k]=0 -> release.
  3. MAX_HOLD!=0 and CNT==MAX_HOLD-1 -> release with TMO=1 for the next cycle.
  4. Otherwise CNT increments, saturating at 255.
- Release: same edge clears GNT to 0 and BUSY to 0, sets PTR=(k+1) mod N_REQ, and enters GAP. GID holds k.
- GAP: lasts exactly 1 cycle with GNT=0; TMO is deasserted at the end of GAP. Then enters IDLE and evaluates REQ normally. There are no back-to-back grants; minimum grant-to-grant spacing is 1 idle cycle.
- Simultaneous events: DONE together with timeout counts as a normal release, TMO=0. REQ changes of non-owners during OWN are ignored.
- Fairness: a continuously requesting set of M requesters each receives a grant within M grant periods.
- GNT is never multi-hot. GNT bits at index >= N_REQ do not exist; GID < N_REQ always.
- DONE asserted while IDLE or GAP is ignored.

Test Plan:
- Reset: hold CD=1 two cycles with REQ=4'b1111, DONE=1 -> GNT=0, BUSY=0, TMO=0, GID=0; first edge after CD falls -> GNT=4'b0001.
- Round-robin: REQ=4'b1111 constant, DONE pulsed 3 cycles after each grant -> grant order 0,1,2,3,0, with exactly 1 GNT=0 cycle between grants.
- Wrap/skip: PTR=3 (after a grant to 2), REQ=4'b0101 -> GNT=4'b0001, GID=0; after release, GNT=4'b0100.
- Timeout: MAX_HOLD=16, REQ=4'b0010 held, DONE=0 -> GNT=4'b0010 for exactly 16 cycles, then GNT=0 with TMO=1 for 1 cycle; re-grant to 1 follows the GAP cycle.
- Collision: DONE=1 on the edge where CNT==15 -> release with TMO=0. Separately, drop REQ[k] mid-grant -> GNT=0 on the next edge, TMO=0.
- Reset mid-grant: assert CD while GNT=4'b0100 -> next edge GNT=0, PTR=0. With REQ=4'b0110 after reset -> grant goes to 1.

Source files
------------

// File: rtl/rr_gate_arbiter_if.sv
// Request/grant bundle between the cell-test sequencers and the shared
// evaluation slot arbiter.
interface rr_gate_arbiter_if #(
    parameter int unsigned N_REQ = 4
) ();
    logic [N_REQ-1:0] REQ;
    logic             DONE;
    logic [N_REQ-1:0] GNT;
    logic [2:0]       GID;
    logic             BUSY;
    logic             TMO;

    modport master (
        output REQ, DONE,
        input  GNT, GID, BUSY, TMO
    );

    modport slave (
        input  REQ, DONE,
        output GNT, GID, BUSY, TMO
    );
endinterface

// File: rtl/rr_gate_arbiter.sv
// Round-robin arbiter for one timed primitive-cell test slot; registered one-hot
// grant held until DONE, request drop, or hold timeout.
module rr_gate_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic              CK,
    input  logic              CD,
    rr_gate_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

    localparam logic [2:0] LAST_IDX   = 3'(N_REQ - 1);
    localparam bit         TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST  = TIMEOUT_EN ? 8'(MAX_HOLD - 1) : 8'd0;

    state_t           state;
    logic [N_REQ-1:0] gnt;
    logic [2:0]       gid;
    logic [2:0]       ptr;
    logic [7:0]       cnt;
    logic             busy;
    logic             tmo;

    logic             pick_valid;
    logic [2:0]       pick_idx;
    logic [2:0]       cand;
    logic [N_REQ-1:0] pick_oh;
    logic             owner_req;

    // Scan requesters starting at ptr, wrapping at N_REQ.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = ptr;
        for (int unsigned s = 0; s < N_REQ; s++) begin
            for (int unsigned j = 0; j < N_REQ; j++) begin
                if (!pick_valid && cand == 3'(j) && bus.REQ[j]) begin
                    pick_valid = 1'b1;
                    pick_idx   = 3'(j);
                end
            end
            cand = (cand == LAST_IDX) ? 3'd0 : cand + 3'd1;
        end
    end

    always_comb begin
        pick_oh = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            pick_oh[j] = (pick_idx == 3'(j));
        end
    end

    assign owner_req = |(bus.REQ & gnt);

    always_ff @(posedge CK) begin
        if (CD) begin
            state <= IDLE;
            gnt   <= '0;
            gid   <= '0;
            ptr   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            tmo   <= 1'b0;
        end else begin
            case (state)
                // The edge that closes GAP arbitrates like IDLE so grants are
                // separated by exactly one empty cycle.
                IDLE, GAP: begin
                    tmo <= 1'b0;
                    if (pick_valid) begin
                        gnt   <= pick_oh;
                        gid   <= pick_idx;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        state <= OWN;
                    end else begin
                        state <= IDLE;
                    end
                end
                OWN: begin
                    if (bus.DONE || !owner_req || (TIMEOUT_EN && cnt == HOLD_LAST)) begin
                        gnt   <= '0;
                        busy  <= 1'b0;
                        ptr   <= (gid == LAST_IDX) ? 3'd0 : gid + 3'd1;
                        tmo   <= !bus.DONE && owner_req;
                        state <= GAP;
                    end else if (cnt != 8'hFF) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.GNT  = gnt;
    assign bus.GID  = gid;
    assign bus.BUSY = busy;
    assign bus.TMO  = tmo;
endmodule

// File: tb/tb_rr_gate_arbiter.sv
// Directed bench for rr_gate_arbiter: expected outputs are queued with each
// stimulus step and compared after the following clock edge.
module tb_rr_gate_arbiter;
    typedef struct {
        string      tag;
        logic [3:0] gnt;
        logic [2:0] gid;
        logic       busy;
        logic       tmo;
    } exp_t;

    logic CK;
    logic CD;
    int   tests;
    int   errors;
    exp_t exp_q[$];

    rr_gate_arbiter_if #(.N_REQ(4)) bus ();

    rr_gate_arbiter #(
        .N_REQ    (4),
        .MAX_HOLD (16)
    ) dut (
        .CK  (CK),
        .CD  (CD),
        .bus (bus)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input string tag, input logic [3:0] g, input logic [2:0] id,
                        input logic b, input logic t);
        exp_t e;
        exp_t want;
        e.tag = tag; e.gnt = g; e.gid = id; e.busy = b; e.tmo = t;
        exp_q.push_back(e);
        @(posedge CK);
        #1;
        want = exp_q.pop_front();
        tests++;
        assert ({bus.GNT, bus.GID, bus.BUSY, bus.TMO} === {want.gnt, want.gid, want.busy, want.tmo})
        else begin
            errors++;
            $error("FAIL %s: got gnt=%b gid=%0d busy=%b tmo=%b, want gnt=%b gid=%0d busy=%b tmo=%b",
                   want.tag, bus.GNT, bus.GID, bus.BUSY, bus.TMO,
                   want.gnt, want.gid, want.busy, want.tmo);
        end
        tests++;
        assert ($onehot0(bus.GNT) && (bus.BUSY === (|bus.GNT)))
        else begin
            errors++;
            $error("FAIL %s_onehot: got gnt=%b busy=%b, want one-hot-or-zero gnt with busy=|gnt",
                   want.tag, bus.GNT, bus.BUSY);
        end
    endtask

    initial begin
        logic [3:0] oh;
        tests  = 0;
        errors = 0;

        // Reset with all requests and DONE asserted
        CD = 1'b1; bus.REQ = 4'b1111; bus.DONE = 1'b1;
        step("reset1", 4'b0000, 3'd0, 1'b0, 1'b0);
        step("reset2", 4'b0000, 3'd0, 1'b0, 1'b0);
        CD = 1'b0; bus.DONE = 1'b0;
        step("first_grant", 4'b0001, 3'd0, 1'b1, 1'b0);

        // Round-robin: DONE three cycles after each grant
        for (int k = 0; k < 4; k++) begin
            oh = 4'b0001 << k;
            step("rr_hold1", oh, 3'(k), 1'b1, 1'b0);
            step("rr_hold2", oh, 3'(k), 1'b1, 1'b0);
            bus.DONE = 1'b1;
            step("rr_release", 4'b0000, 3'(k), 1'b0, 1'b0);
            bus.DONE = 1'b0;
            oh = 4'b0001 << ((k + 1) % 4);
            step("rr_next", oh, 3'((k + 1) % 4), 1'b1, 1'b0);
        end

        // Wrap/skip: grant to 2 leaves ptr=3, then REQ=0101 wraps to 0
        bus.DONE = 1'b1; bus.REQ = 4'b0100;
        step("ws_rel0", 4'b0000, 3'd0, 1'b0, 1'b0);
        bus.DONE = 1'b0;
        step("ws_grant2", 4'b0100, 3'd2, 1'b1, 1'b0);
        bus.REQ = 4'b0101; bus.DONE = 1'b1;
        step("ws_rel2", 4'b0000, 3'd2, 1'b0, 1'b0);
        bus.DONE = 1'b0;
        step("ws_wrap0", 4'b0001, 3'd0, 1'b1, 1'b0);
        bus.DONE = 1'b1;
        step("ws_rel0b", 4'b0000, 3'd0, 1'b0, 1'b0);
        bus.DONE = 1'b0;
        step("ws_skip2", 4'b0100, 3'd2, 1'b1, 1'b0);

        // Owner drops its request mid-grant
        bus.REQ = 4'b0010;
        step("drop_rel", 4'b0000, 3'd2, 1'b0, 1'b0);

        // Timeout: grant to 1 held 16 cycles, then TMO pulse
        step("to_grant", 4'b0010, 3'd1, 1'b1, 1'b0);
        for (int c = 1; c < 16; c++) begin
            step("to_hold", 4'b0010, 3'd1, 1'b1, 1'b0);
        end
        step("to_revoke", 4'b0000, 3'd1, 1'b0, 1'b1);
        step("to_regrant", 4'b0010, 3'd1, 1'b1, 1'b0);

        // Collision: DONE on the timeout edge is a normal release
        for (int c = 1; c < 16; c++) begin
            step("col_hold", 4'b0010, 3'd1, 1'b1, 1'b0);
        end
        bus.DONE = 1'b1;
        step("col_release", 4'b0000, 3'd1, 1'b0, 1'b0);
        bus.DONE = 1'b0;
        step("col_regrant", 4'b0010, 3'd1, 1'b1, 1'b0);
        step("col_hold2", 4'b0010, 3'd1, 1'b1, 1'b0);
        bus.REQ = 4'b0000;
        step("drop_rel1", 4'b0000, 3'd1, 1'b0, 1'b0);
        step("idle", 4'b0000, 3'd1, 1'b0, 1'b0);

        // DONE while idle is ignored
        bus.DONE = 1'b1;
        step("idle_done", 4'b0000, 3'd1, 1'b0, 1'b0);
        bus.DONE = 1'b0;

        // Reset mid-grant clears pointer
        bus.REQ = 4'b0100;
        step("mid_grant2", 4'b0100, 3'd2, 1'b1, 1'b0);
        CD = 1'b1; bus.REQ = 4'b0110;
        step("mid_reset", 4'b0000, 3'd0, 1'b0, 1'b0);
        CD = 1'b0;
        step("post_reset", 4'b0010, 3'd1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
